// File: rtl/glitch_sweep.sv
// Parameter-sweep scheduler feeding the glitch engine's command FIFO.
// Steps a (delay, width) grid, fires one attempt per FIFO fill and samples the target hit flag.
module glitch_sweep #(
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE_W   = 16,
    parameter int REPEAT_W   = 8
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [15:0]         delay_start,
    input  logic [15:0]         delay_stop,
    input  logic [15:0]         delay_step,
    input  logic [7:0]          width_start,
    input  logic [7:0]          width_stop,
    input  logic [7:0]          width_step,
    input  logic [7:0]          mode,
    input  logic [REPEAT_W-1:0] repeats,
    input  logic [SETTLE_W-1:0] settle,
    input  logic                hit,
    input  logic                fifo_full,
    input  logic                glitch_ready,
    output logic                fifo_we,
    output logic [31:0]         fifo_data,
    output logic                busy,
    output logic                done,
    output logic                hit_found,
    output logic [15:0]         cur_delay,
    output logic [7:0]          cur_width,
    output logic [31:0]         attempt_cnt
);

    localparam int IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FIFO_DEPTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_ARM    = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_STEP   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]          state;
    logic [IDX_W-1:0]    word_idx;
    logic [REPEAT_W-1:0] rep_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                abort_pend;

    logic [15:0]         delay_stop_q;
    logic [15:0]         delay_step_q;
    logic [7:0]          width_start_q;
    logic [7:0]          width_stop_q;
    logic [7:0]          width_step_q;
    logic [7:0]          mode_q;
    logic [REPEAT_W-1:0] repeats_q;
    logic [SETTLE_W-1:0] settle_q;

    logic [REPEAT_W:0]   rep_next;
    logic [REPEAT_W:0]   rep_limit;
    logic                rep_more;
    logic [7:0]          width_inc;
    logic [8:0]          width_next;
    logic                width_ok;
    logic [15:0]         delay_inc;
    logic [16:0]         delay_next;
    logic                delay_ok;

    // FIFO handshake: a word is transferred on every rising edge where fifo_we=1;
    // fifo_we is only raised while LOAD has words left and the FIFO reports room (fifo_full=0).
    assign fifo_we = (state == S_LOAD) && !fifo_full;
    assign busy    = (state != S_IDLE) && (state != S_DONE);
    assign done    = (state == S_DONE);

    always_comb begin
        fifo_data = 32'h0;
        if (fifo_we && (word_idx == '0)) begin
            fifo_data = {cur_delay, cur_width, mode_q};
        end
    end

    // Axis advance is done one bit wider so a carry past the top of the range ends the axis.
    always_comb begin
        rep_next   = {1'b0, rep_cnt} + {{REPEAT_W{1'b0}}, 1'b1};
        rep_limit  = (repeats_q == '0) ? {{REPEAT_W{1'b0}}, 1'b1} : {1'b0, repeats_q};
        rep_more   = rep_next < rep_limit;
        width_inc  = (width_step_q == 8'd0) ? 8'd1 : width_step_q;
        width_next = {1'b0, cur_width} + {1'b0, width_inc};
        width_ok   = !width_next[8] && (width_next[7:0] <= width_stop_q);
        delay_inc  = (delay_step_q == 16'd0) ? 16'd1 : delay_step_q;
        delay_next = {1'b0, cur_delay} + {1'b0, delay_inc};
        delay_ok   = !delay_next[16] && (delay_next[15:0] <= delay_stop_q);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state         <= S_IDLE;
            word_idx      <= '0;
            rep_cnt       <= '0;
            settle_cnt    <= '0;
            abort_pend    <= 1'b0;
            hit_found     <= 1'b0;
            cur_delay     <= 16'd0;
            cur_width     <= 8'd0;
            attempt_cnt   <= 32'd0;
            delay_stop_q  <= 16'd0;
            delay_step_q  <= 16'd0;
            width_start_q <= 8'd0;
            width_stop_q  <= 8'd0;
            width_step_q  <= 8'd0;
            mode_q        <= 8'd0;
            repeats_q     <= '0;
            settle_q      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        delay_stop_q  <= delay_stop;
                        delay_step_q  <= delay_step;
                        width_start_q <= width_start;
                        width_stop_q  <= width_stop;
                        width_step_q  <= width_step;
                        mode_q        <= mode;
                        repeats_q     <= repeats;
                        settle_q      <= settle;
                        cur_delay     <= delay_start;
                        cur_width     <= width_start;
                        hit_found     <= 1'b0;
                        attempt_cnt   <= 32'd0;
                        rep_cnt       <= '0;
                        word_idx      <= '0;
                        abort_pend    <= 1'b0;
                        state         <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Abort is deferred so the FIFO is never left half filled.
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (fifo_we) begin
                        if (word_idx == LAST_IDX) begin
                            word_idx    <= '0;
                            attempt_cnt <= attempt_cnt + 32'd1;
                            state       <= S_ARM;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                end
                S_ARM: begin
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (!glitch_ready) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (glitch_ready) begin
                        settle_cnt <= settle_q;
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (hit) begin
                        hit_found <= 1'b1;
                        state     <= S_DONE;
                    end else if (abort || abort_pend) begin
                        state <= S_DONE;
                    end else if (settle_cnt <= SETTLE_W'(1)) begin
                        state <= S_STEP;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                S_STEP: begin
                    if (abort) begin
                        state <= S_DONE;
                    end else if (rep_more) begin
                        rep_cnt <= rep_next[REPEAT_W-1:0];
                        state   <= S_LOAD;
                    end else begin
                        rep_cnt <= '0;
                        if (width_ok) begin
                            cur_width <= width_next[7:0];
                            state     <= S_LOAD;
                        end else begin
                            cur_width <= width_start_q;
                            if (delay_ok) begin
                                cur_delay <= delay_next[15:0];
                                state     <= S_LOAD;
                            end else begin
                                state <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    abort_pend <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glitch_sweep.sv
// Directed bench for glitch_sweep: a FIFO/engine model, a write scoreboard and done/status checks.
module tb_glitch_sweep;

    localparam int DEPTH = 4;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] delay_start = 16'd0;
    logic [15:0] delay_stop = 16'd0;
    logic [15:0] delay_step = 16'd0;
    logic [7:0]  width_start = 8'd0;
    logic [7:0]  width_stop = 8'd0;
    logic [7:0]  width_step = 8'd0;
    logic [7:0]  mode = 8'h5A;
    logic [7:0]  repeats = 8'd1;
    logic [15:0] settle = 16'd3;
    logic        hit;
    logic        fifo_full;
    logic        glitch_ready;
    logic        fifo_we;
    logic [31:0] fifo_data;
    logic        busy;
    logic        done;
    logic        hit_found;
    logic [15:0] cur_delay;
    logic [7:0]  cur_width;
    logic [31:0] attempt_cnt;

    always #5 clk_in = ~clk_in;

    glitch_sweep #(.FIFO_DEPTH(DEPTH), .SETTLE_W(16), .REPEAT_W(8)) dut (
        .clk_in(clk_in), .rst(rst), .start(start), .abort(abort),
        .delay_start(delay_start), .delay_stop(delay_stop), .delay_step(delay_step),
        .width_start(width_start), .width_stop(width_stop), .width_step(width_step),
        .mode(mode), .repeats(repeats), .settle(settle), .hit(hit),
        .fifo_full(fifo_full), .glitch_ready(glitch_ready),
        .fifo_we(fifo_we), .fifo_data(fifo_data), .busy(busy), .done(done),
        .hit_found(hit_found), .cur_delay(cur_delay), .cur_width(cur_width),
        .attempt_cnt(attempt_cnt)
    );

    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int n_writes = 0;
    logic bp = 1'b0;
    int hit_at = 0;

    int   fill = 0;
    int   eng_ph = 0;
    int   eng_tmr = 0;
    int   hit_tmr = 0;
    int   eng_done = 0;
    logic we_seen;
    logic rst_seen;
    logic start_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every FIFO write pops the scoreboard.
    always @(negedge clk_in) begin
        if (done === 1'b1) done_cnt++;
        if (fifo_full === 1'b1) check("no_we_when_full", {31'd0, fifo_we}, 32'd0);
        if (fifo_we === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got data 0x%08h, expected no write", fifo_data);
            end else begin
                check("fifo_word", fifo_data, exp_q.pop_front());
            end
        end
    end

    // FIFO + glitch engine model: fills to DEPTH, drops ready, runs, then drains and raises ready.
    initial begin
        glitch_ready = 1'b1;
        hit = 1'b0;
        fifo_full = 1'b0;
        forever begin
            @(negedge clk_in);
            we_seen = fifo_we;
            rst_seen = rst;
            start_seen = start;
            @(posedge clk_in);
            #1;
            if (rst_seen) begin
                fill = 0; eng_ph = 0; eng_tmr = 0; hit_tmr = 0; eng_done = 0;
                glitch_ready = 1'b1;
                hit = 1'b0;
            end else begin
                if (start_seen) eng_done = 0;
                if (we_seen) fill++;
                case (eng_ph)
                    0: if (fill >= DEPTH) begin eng_ph = 1; eng_tmr = 2; end
                    1: begin
                        eng_tmr--;
                        if (eng_tmr == 0) begin glitch_ready = 1'b0; eng_ph = 2; eng_tmr = 3; end
                    end
                    default: begin
                        eng_tmr--;
                        if (eng_tmr == 0) begin
                            glitch_ready = 1'b1;
                            fill = 0;
                            eng_ph = 0;
                            eng_done++;
                            if (eng_done == hit_at) hit_tmr = 4;
                        end
                    end
                endcase
                hit = (hit_tmr > 0);
                if (hit_tmr > 0) hit_tmr--;
            end
            fifo_full = (fill >= DEPTH) || bp;
        end
    end

    task automatic set_cfg(input logic [15:0] ds, input logic [15:0] dp, input logic [15:0] dt,
                           input logic [7:0] ws, input logic [7:0] wp, input logic [7:0] wt,
                           input logic [7:0] reps, input logic [15:0] st);
        delay_start = ds; delay_stop = dp; delay_step = dt;
        width_start = ws; width_stop = wp; width_step = wt;
        repeats = reps; settle = st;
    endtask

    task automatic push_attempt(input logic [15:0] d, input logic [7:0] w);
        exp_q.push_back({d, w, mode});
        for (int i = 1; i < DEPTH; i++) exp_q.push_back(32'h0);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input int base, output int cycles);
        cycles = 0;
        while (done_cnt == base && cycles < budget) begin
            @(posedge clk_in); #1;
            cycles++;
        end
        if (done_cnt == base) begin
            n_checks++;
            $display("FAIL %s: no done pulse within %0d cycles, expected one", name, budget);
        end
    endtask

    task automatic finish_test(input string name, input int base, input int n_exp_writes, input int wbase);
        repeat (12) @(posedge clk_in);
        #1;
        check({name, "_done_once"}, done_cnt - base, 1);
        check({name, "_queue_drained"}, exp_q.size(), 0);
        check({name, "_write_count"}, n_writes - wbase, n_exp_writes);
        check({name, "_busy_low"}, {31'd0, busy}, 0);
    endtask

    int base;
    int wbase;
    int cyc;
    int lim;

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_fifo_we", {31'd0, fifo_we}, 0);
        check("rst_fifo_data", fifo_data, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_hit_found", {31'd0, hit_found}, 0);
        check("rst_cur_delay", {16'd0, cur_delay}, 0);
        check("rst_cur_width", {24'd0, cur_width}, 0);
        check("rst_attempt_cnt", attempt_cnt, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;

        // Single point: word 0 = 0x000A035A then three zero words.
        set_cfg(16'd10, 16'd10, 16'd1, 8'd3, 8'd3, 8'd1, 8'd1, 16'd3);
        push_attempt(16'd10, 8'd3);
        base = done_cnt; wbase = n_writes;
        pulse_start();
        check("single_busy", {31'd0, busy}, 1);
        wait_done("single", 500, base, cyc);
        check("single_attempts", attempt_cnt, 1);
        check("single_hit_found", {31'd0, hit_found}, 0);
        finish_test("single", base, 4, wbase);

        // Grid 0..20/10 x 1..5/2, two repeats each; a second start mid-sweep must be ignored.
        set_cfg(16'd0, 16'd20, 16'd10, 8'd1, 8'd5, 8'd2, 8'd2, 16'd3);
        for (int d = 0; d <= 20; d += 10)
            for (int w = 1; w <= 5; w += 2) begin
                push_attempt(16'(d), 8'(w));
                push_attempt(16'(d), 8'(w));
            end
        base = done_cnt; wbase = n_writes;
        pulse_start();
        repeat (30) @(posedge clk_in);
        #1;
        set_cfg(16'd100, 16'd100, 16'd1, 8'd9, 8'd9, 8'd1, 8'd1, 16'd3);
        pulse_start();
        wait_done("grid", 3000, base, cyc);
        check("grid_attempts", attempt_cnt, 18);
        check("grid_hit_found", {31'd0, hit_found}, 0);
        finish_test("grid", base, 72, wbase);

        // Hit during SETTLE of attempt 4 -> stop at (0,3).
        set_cfg(16'd0, 16'd20, 16'd10, 8'd1, 8'd5, 8'd2, 8'd2, 16'd3);
        hit_at = 4;
        push_attempt(16'd0, 8'd1); push_attempt(16'd0, 8'd1);
        push_attempt(16'd0, 8'd3); push_attempt(16'd0, 8'd3);
        base = done_cnt; wbase = n_writes;
        pulse_start();
        wait_done("hit", 1000, base, cyc);
        check("hit_found", {31'd0, hit_found}, 1);
        check("hit_cur_delay", {16'd0, cur_delay}, 0);
        check("hit_cur_width", {24'd0, cur_width}, 3);
        check("hit_attempts", attempt_cnt, 4);
        finish_test("hit", base, 16, wbase);
        hit_at = 0;

        // Backpressure for 5 cycles in the middle of LOAD.
        set_cfg(16'h1234, 16'h1234, 16'd1, 8'h56, 8'h56, 8'd1, 8'd1, 16'd3);
        push_attempt(16'h1234, 8'h56);
        base = done_cnt; wbase = n_writes;
        pulse_start();
        @(posedge clk_in); #1;
        bp = 1'b1;
        repeat (5) @(posedge clk_in);
        #1;
        bp = 1'b0;
        wait_done("bp", 500, base, cyc);
        check("bp_attempts", attempt_cnt, 1);
        finish_test("bp", base, 4, wbase);

        // Width carry ends the inner axis; delay_step 0 acts as 1; repeats 0 acts as 1.
        set_cfg(16'd5, 16'd7, 16'd0, 8'd250, 8'd255, 8'd10, 8'd0, 16'd3);
        push_attempt(16'd5, 8'd250); push_attempt(16'd6, 8'd250); push_attempt(16'd7, 8'd250);
        base = done_cnt; wbase = n_writes;
        pulse_start();
        wait_done("wrap_a", 1000, base, cyc);
        check("wrap_a_attempts", attempt_cnt, 3);
        finish_test("wrap_a", base, 12, wbase);

        // width_start 255 + 10 must not wrap to 9; settle 0 still runs.
        set_cfg(16'd0, 16'd1, 16'd1, 8'd255, 8'd255, 8'd10, 8'd1, 16'd0);
        push_attempt(16'd0, 8'd255); push_attempt(16'd1, 8'd255);
        base = done_cnt; wbase = n_writes;
        pulse_start();
        wait_done("wrap_b", 1000, base, cyc);
        check("wrap_b_attempts", attempt_cnt, 2);
        finish_test("wrap_b", base, 8, wbase);

        // Delay carry past 16 bits and width start > stop: a single point.
        set_cfg(16'hFFF0, 16'hFFFF, 16'h0020, 8'd9, 8'd4, 8'd1, 8'd1, 16'd1);
        push_attempt(16'hFFF0, 8'd9);
        base = done_cnt; wbase = n_writes;
        pulse_start();
        wait_done("wrap_c", 500, base, cyc);
        check("wrap_c_attempts", attempt_cnt, 1);
        finish_test("wrap_c", base, 4, wbase);

        // Abort during RUN: finish the attempt, then done within two cycles of ready.
        set_cfg(16'd0, 16'd10, 16'd1, 8'd1, 8'd1, 8'd1, 8'd1, 16'd20);
        push_attempt(16'd0, 8'd1);
        base = done_cnt; wbase = n_writes;
        pulse_start();
        lim = 0;
        while (glitch_ready !== 1'b0 && lim < 200) begin @(posedge clk_in); #1; lim++; end
        check("abort_engine_started", {31'd0, glitch_ready}, 0);
        abort = 1'b1;
        @(posedge clk_in); #1;
        abort = 1'b0;
        lim = 0;
        while (glitch_ready !== 1'b1 && lim < 200) begin @(posedge clk_in); #1; lim++; end
        check("abort_waits_engine", done_cnt - base, 0);
        wait_done("abort", 40, base, cyc);
        check("abort_done_fast", {31'd0, (cyc <= 3)}, 1);
        check("abort_attempts", attempt_cnt, 1);
        check("abort_no_hit", {31'd0, hit_found}, 0);
        finish_test("abort", base, 4, wbase);

        // Reset in the middle of LOAD clears every output on the next edge.
        set_cfg(16'h0077, 16'h0077, 16'd1, 8'd1, 8'd1, 8'd1, 8'd1, 16'd3);
        push_attempt(16'h0077, 8'd1);
        base = done_cnt;
        pulse_start();
        @(posedge clk_in); #1;
        rst = 1'b1;
        @(posedge clk_in); #1;
        check("midrst_fifo_we", {31'd0, fifo_we}, 0);
        check("midrst_fifo_data", fifo_data, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_done", {31'd0, done}, 0);
        check("midrst_cur_delay", {16'd0, cur_delay}, 0);
        check("midrst_cur_width", {24'd0, cur_width}, 0);
        check("midrst_attempt_cnt", attempt_cnt, 0);
        @(posedge clk_in); #1;
        rst = 1'b0;
        exp_q.delete();
        repeat (5) @(posedge clk_in);
        #1;
        check("midrst_no_done", done_cnt - base, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench still running, expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end

endmodule
